// File: rtl/audio_pkg.sv
// Shared audio-path types and default I2S framing constants.
// Used by the I2S transmitter and its bit-clock generator.
package audio_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WIDTH_DEF     = 16;
    localparam int SLOT_BITS_DEF = 32;
    localparam int HALF_DIV_DEF  = 3;

    // Position of a frame bit counter within its channel slot.
    function automatic int slot_pos(input int bit_cnt, input int slot_bits);
        return (bit_cnt >= slot_bits) ? bit_cnt - slot_bits : bit_cnt;
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample stream in from the de-emphasis filter, I2S lines and status pulses out.
// The filter side is the master; the transmitter is the slave.
interface i2s_transmitter_if #(
    parameter int width = audio_pkg::WIDTH_DEF
);
    logic signed [width-1:0] in;
    logic                    in_valid;
    logic                    bclk;
    logic                    lrclk;
    logic                    sdata;
    logic                    frame_start;
    logic                    underrun;
    logic                    overrun;

    modport master (
        output in, in_valid,
        input  bclk, lrclk, sdata, frame_start, underrun, overrun
    );

    modport slave (
        input  in, in_valid,
        output bclk, lrclk, sdata, frame_start, underrun, overrun
    );
endinterface

// File: rtl/i2s_transmitter_bclk_gen.sv
// Divides the system clock into the I2S bit clock and flags the cycle
// just before each bclk edge so the frame logic can act on it.
module bclk_gen
    import audio_pkg::*;
#(
    parameter int half_div = HALF_DIV_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_tick_o,
    output logic rise_tick_o
);
    localparam int DW = (half_div > 1) ? $clog2(half_div) : 1;

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          bclk_q, bclk_d;
    logic          terminal;

    always_comb begin
        terminal  = en_i && (int'(div_cnt_q) == half_div - 1);
        div_cnt_d = div_cnt_q;
        bclk_d    = bclk_q;
        if (!en_i) begin
            div_cnt_d = '0;
            bclk_d    = 1'b0;
        end else if (terminal) begin
            div_cnt_d = '0;
            bclk_d    = !bclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk_o      = bclk_q;
    assign fall_tick_o = terminal && bclk_q;
    assign rise_tick_o = terminal && !bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Mono-to-stereo I2S transmitter: one-sample holding register feeding a frame
// register that is shifted out MSB first in both slots, with under/overrun flags.
module i2s_transmitter
    import audio_pkg::*;
#(
    parameter int width     = WIDTH_DEF,
    parameter int slot_bits = SLOT_BITS_DEF,
    parameter int half_div  = HALF_DIV_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    i2s_transmitter_if.slave bus
);
    localparam int BW = $clog2(2 * slot_bits);
    localparam int IW = $clog2(width);

    state_t          state_q, state_d;
    logic            fresh_q, fresh_d;
    logic [width-1:0] hold_q, hold_d;
    logic [width-1:0] frame_q, frame_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic            lrclk_q, lrclk_d;
    logic            sdata_q, sdata_d;
    logic            frame_start_q, frame_start_d;
    logic            underrun_q, underrun_d;
    logic            overrun_q, overrun_d;

    logic            fall_tick, rise_tick, bclk, load;
    int              bit_next, pos;
    logic [IW-1:0]   bit_idx;

    bclk_gen #(.half_div(half_div)) u_bclk_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en_i        (state_q == RUN),
        .bclk_o      (bclk),
        .fall_tick_o (fall_tick),
        .rise_tick_o (rise_tick)
    );

    // Frame sequencing happens only on falling bclk ticks; the first in_valid
    // in IDLE counts as a load so the first frame starts immediately.
    always_comb begin
        state_d       = state_q;
        fresh_d       = fresh_q;
        hold_d        = hold_q;
        frame_d       = frame_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;
        overrun_d     = 1'b0;
        bit_next      = int'(bit_cnt_q);
        pos           = 0;
        bit_idx       = '0;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d  = RUN;
                    load     = 1'b1;
                    bit_next = 0;
                    lrclk_d  = 1'b0;
                    sdata_d  = 1'b0;
                end
            end
            RUN: begin
                if (fall_tick) begin
                    bit_next = (int'(bit_cnt_q) == 2 * slot_bits - 1) ? 0 : int'(bit_cnt_q) + 1;
                    load     = (bit_next == 0);
                    pos      = slot_pos(bit_next, slot_bits);
                    lrclk_d  = (bit_next >= slot_bits);
                    bit_idx  = IW'(width - pos);
                    sdata_d  = (pos >= 1 && pos <= width) ? frame_q[bit_idx] : 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        bit_cnt_d = BW'(bit_next);

        // A sample arriving in the load cycle bypasses straight into the frame.
        if (load) begin
            frame_d       = bus.in_valid ? bus.in : hold_q;
            frame_start_d = 1'b1;
            underrun_d    = !fresh_q && !bus.in_valid;
            fresh_d       = 1'b0;
        end

        if (bus.in_valid) begin
            hold_d = bus.in;
            if (!load) begin
                fresh_d   = 1'b1;
                overrun_d = fresh_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fresh_q       <= 1'b0;
            hold_q        <= '0;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            lrclk_q       <= 1'b1;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fresh_q       <= fresh_d;
            hold_q        <= hold_d;
            frame_q       <= frame_d;
            bit_cnt_q     <= bit_cnt_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            overrun_q     <= overrun_d;
        end
    end

    // The divider can never report both bclk edges in the same cycle.
    assert property (@(posedge clk) disable iff (!reset_n) !(fall_tick && rise_tick));

    assign bus.bclk        = bclk;
    assign bus.lrclk       = lrclk_q;
    assign bus.sdata       = sdata_q;
    assign bus.frame_start = frame_start_q;
    assign bus.underrun    = underrun_q;
    assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for the I2S transmitter at default parameters: reset, basic
// frame, underrun, overrun, load-cycle bypass and mid-frame reset.
module tb_i2s_transmitter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    i2s_transmitter_if #(.width(16)) bus ();

    i2s_transmitter #(.width(16), .slot_bits(32), .half_div(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Strobe one sample from a negedge; returns at the negedge after the capture edge.
    task automatic applyStimulus(input logic [15:0] value);
        bus.in       = value;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic idleCycles(input int n, output int activity);
        activity = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.bclk !== 1'b0 || bus.lrclk !== 1'b1 || bus.sdata !== 1'b0) activity++;
        end
    endtask

    // Walks one 384-cycle frame from a frame_start negedge to the next, sampling
    // sdata on each rising bclk and optionally strobing up to two samples.
    task automatic runFrame(input int injA, input logic [15:0] valA,
                            input int injB, input logic [15:0] valB,
                            output logic [31:0] leftW, output logic [31:0] rightW,
                            output int nLeft, output int nRight,
                            output int firstRise, output int firstHigh,
                            output int ovStep, output int ovCount);
        logic prevBclk;
        prevBclk  = bus.bclk;
        leftW     = '0;
        rightW    = '0;
        nLeft     = 0;
        nRight    = 0;
        firstRise = -1;
        firstHigh = -1;
        ovStep    = -1;
        ovCount   = 0;
        for (int s = 1; s <= 384; s++) begin
            @(negedge clk);
            if (bus.bclk === 1'b1 && prevBclk === 1'b0) begin
                if (firstRise < 0) firstRise = s;
                if (bus.lrclk === 1'b0) begin
                    leftW = {leftW[30:0], bus.sdata};
                    nLeft++;
                end else begin
                    rightW = {rightW[30:0], bus.sdata};
                    nRight++;
                end
            end
            if (bus.sdata === 1'b1 && firstHigh < 0) firstHigh = s;
            if (bus.overrun === 1'b1) begin
                ovCount++;
                if (ovStep < 0) ovStep = s;
            end
            prevBclk     = bus.bclk;
            bus.in_valid = (s == injA) || (s == injB);
            bus.in       = (s == injB) ? valB : valA;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] lw, rw;
        int nl, nr, fr, fh, os, oc, act;
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        bus.in       = '0;
        bus.in_valid = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("rst_bclk", bus.bclk, 1'b0);
        checkOutput("rst_lrclk", bus.lrclk, 1'b1);
        checkOutput("rst_sdata", bus.sdata, 1'b0);
        checkOutput("rst_fs", bus.frame_start, 1'b0);
        checkOutput("rst_ur", bus.underrun, 1'b0);
        checkOutput("rst_or", bus.overrun, 1'b0);

        reset_n = 1'b1;
        idleCycles(20, act);
        checkOutput("idle_quiet", act, 0);

        $display("[TB] basic frame 0x8001");
        applyStimulus(16'h8001);
        checkOutput("start_fs", bus.frame_start, 1'b1);
        checkOutput("start_ur", bus.underrun, 1'b0);
        checkOutput("start_lrclk", bus.lrclk, 1'b0);
        checkOutput("start_bclk", bus.bclk, 1'b0);
        runFrame(-1, 16'h0, -1, 16'h0, lw, rw, nl, nr, fr, fh, os, oc);
        checkOutput("f1_first_rise", fr, 3);
        checkOutput("f1_msb_time", fh, 6);
        checkOutput("f1_nleft", nl, 32);
        checkOutput("f1_nright", nr, 32);
        checkOutput("f1_left", lw, 32'h4000_8000);
        checkOutput("f1_right", rw, 32'h4000_8000);
        checkOutput("f1_ov", oc, 0);
        checkOutput("f2_fs", bus.frame_start, 1'b1);
        checkOutput("f2_ur", bus.underrun, 1'b1);
        checkOutput("f2_lrclk", bus.lrclk, 1'b0);

        $display("[TB] underrun repeat plus overrun");
        runFrame(50, 16'h1234, 100, 16'h5678, lw, rw, nl, nr, fr, fh, os, oc);
        checkOutput("f2_left", lw, 32'h4000_8000);
        checkOutput("f2_right", rw, 32'h4000_8000);
        checkOutput("f2_ov_step", os, 101);
        checkOutput("f2_ov_count", oc, 1);
        checkOutput("f3_fs", bus.frame_start, 1'b1);
        checkOutput("f3_ur", bus.underrun, 1'b0);

        $display("[TB] frame 0x5678 with bypass at load");
        runFrame(383, 16'h7FFF, -1, 16'h0, lw, rw, nl, nr, fr, fh, os, oc);
        checkOutput("f3_left", lw, 32'h2B3C_0000);
        checkOutput("f3_right", rw, 32'h2B3C_0000);
        checkOutput("f3_ov", oc, 0);
        checkOutput("f4_fs", bus.frame_start, 1'b1);
        checkOutput("f4_ur", bus.underrun, 1'b0);

        runFrame(-1, 16'h0, -1, 16'h0, lw, rw, nl, nr, fr, fh, os, oc);
        checkOutput("f4_left", lw, 32'h3FFF_8000);
        checkOutput("f4_right", rw, 32'h3FFF_8000);
        checkOutput("f4_ov", oc, 0);
        checkOutput("f5_fs", bus.frame_start, 1'b1);
        checkOutput("f5_ur", bus.underrun, 1'b1);

        $display("[TB] reset mid-frame");
        repeat (123) @(negedge clk);
        checkOutput("mid_bclk_pre", bus.bclk, 1'b1);
        checkOutput("mid_lrclk_pre", bus.lrclk, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_bclk", bus.bclk, 1'b0);
        checkOutput("mid_lrclk", bus.lrclk, 1'b1);
        checkOutput("mid_sdata", bus.sdata, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        idleCycles(20, act);
        checkOutput("post_rst_quiet", act, 0);
        applyStimulus(16'h1234);
        checkOutput("restart_fs", bus.frame_start, 1'b1);
        checkOutput("restart_ur", bus.underrun, 1'b0);
        checkOutput("restart_lrclk", bus.lrclk, 1'b0);
        runFrame(-1, 16'h0, -1, 16'h0, lw, rw, nl, nr, fr, fh, os, oc);
        checkOutput("f6_first_rise", fr, 3);
        checkOutput("f6_left", lw, 32'h091A_0000);
        checkOutput("f6_right", rw, 32'h091A_0000);
        checkOutput("f7_fs", bus.frame_start, 1'b1);
        checkOutput("f7_ur", bus.underrun, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
